// File: rtl/lsu_if.sv
// Request/response channel between the execute stage and the load/store unit.
// The core drives requests on master; the LSU answers on slave.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_funct3,
    output req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3,
    input  req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one request at a time, alignment/range checks,
// RAM access sequencing and load data extension.
module lsu #(
  parameter int N = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  lsu_if.slave        bus,
  output logic        ram_we,
  output logic [1:0]  ram_mem_ctrl,
  output logic [31:0] ram_address,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam logic [1:0] STORE_B  = 2'b00;
  localparam logic [1:0] STORE_HW = 2'b01;
  localparam logic [1:0] STORE_W  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_RDATA,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;
  logic        r_ram_we;
  logic [1:0]  r_ram_mem_ctrl;
  logic [31:0] r_ram_address;
  logic [31:0] r_ram_wdata;
  logic [2:0]  r_funct3;

  logic        w_accept;
  logic [1:0]  w_off;
  logic [29:0] w_word;
  logic        w_oor;
  logic        w_bad_f3;
  logic        w_mis;
  logic        w_err;
  logic [1:0]  w_ctrl;
  logic [31:0] w_sh;
  logic [31:0] w_ext;

  assign w_accept = bus.req_valid
                  & (r_state == S_IDLE);
  assign w_off    = bus.req_addr[1:0];
  assign w_word   = bus.req_addr[31:2];
  assign w_oor    = (w_word >> N) != 30'd0;
  assign w_err    = w_bad_f3 | w_mis | w_oor;

  always_comb begin
    w_bad_f3 = 1'b0;
    w_mis    = 1'b0;
    w_ctrl   = STORE_W;
    unique case (bus.req_funct3)
      3'b000: w_ctrl = STORE_B;
      3'b001: begin
        w_ctrl = STORE_HW;
        w_mis  = (w_off == 2'd3);
      end
      3'b010: begin
        w_ctrl = STORE_W;
        w_mis  = (w_off != 2'd0);
      end
      3'b100: begin
        w_ctrl   = STORE_B;
        w_bad_f3 = bus.req_we;
      end
      3'b101: begin
        w_ctrl   = STORE_HW;
        w_mis    = (w_off == 2'd3);
        w_bad_f3 = bus.req_we;
      end
      default: w_bad_f3 = 1'b1;
    endcase
  end

  // Lane select uses the held address offset
  assign w_sh = ram_rdata
              >> {r_ram_address[1:0], 3'b000};

  always_comb begin
    w_ext = ram_rdata;
    case (r_funct3)
      3'b000: w_ext = {{24{w_sh[7]}}, w_sh[7:0]};
      3'b001: w_ext = {{16{w_sh[15]}}, w_sh[15:0]};
      3'b100: w_ext = {24'd0, w_sh[7:0]};
      3'b101: w_ext = {16'd0, w_sh[15:0]};
      default: w_ext = ram_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_err)           w_next = S_DONE;
          else if (bus.req_we) w_next = S_WRITE;
          else                 w_next = S_READ;
        end
      end
      S_WRITE: w_next = S_DONE;
      S_READ:  w_next = S_RDATA;
      S_RDATA: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid   <= 1'b0;
      r_resp_err     <= 1'b0;
      r_resp_rdata   <= 32'd0;
      r_ram_we       <= 1'b0;
      r_ram_mem_ctrl <= 2'd0;
      r_ram_address  <= 32'd0;
      r_ram_wdata    <= 32'd0;
      r_funct3       <= 3'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= 32'd0;
          if (w_accept) begin
            if (w_err) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
            end else begin
              r_ram_address  <= bus.req_addr;
              r_ram_mem_ctrl <= w_ctrl;
              r_funct3       <= bus.req_funct3;
              if (bus.req_we) begin
                r_ram_we    <= 1'b1;
                r_ram_wdata <= bus.req_wdata;
              end
            end
          end
        end
        S_WRITE: begin
          r_ram_we     <= 1'b0;
          r_resp_valid <= 1'b1;
        end
        S_READ: begin
          r_ram_we <= 1'b0;
        end
        S_RDATA: begin
          r_resp_rdata <= w_ext;
          r_resp_valid <= 1'b1;
        end
        S_DONE: begin
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= 32'd0;
        end
        default: r_ram_we <= 1'b0;
      endcase
    end
  end

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_err   = r_resp_err;
  assign bus.resp_rdata = r_resp_rdata;
  assign ram_we         = r_ram_we;
  assign ram_mem_ctrl   = r_ram_mem_ctrl;
  assign ram_address    = r_ram_address;
  assign ram_wdata      = r_ram_wdata;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a behavioural 1-cycle RAM.
// Expected values are hand-computed constants.
module tb_lsu;
  localparam logic [1:0] ST_B  = 2'b00;
  localparam logic [1:0] ST_HW = 2'b01;
  localparam logic [1:0] ST_W  = 2'b10;

  logic        clk;
  logic        rst_n;
  logic        ram_we;
  logic [1:0]  ram_mem_ctrl;
  logic [31:0] ram_address;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int total;
  int bad;

  lsu_if bus();

  lsu #(.N(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .ram_we       (ram_we),
    .ram_mem_ctrl (ram_mem_ctrl),
    .ram_address  (ram_address),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  logic [7:0]  rw;
  logic [4:0]  rsh;
  assign rw  = ram_address[9:2];
  assign rsh = {ram_address[1:0], 3'b000};

  always @(posedge clk) begin
    if (ram_we) begin
      case (ram_mem_ctrl)
        ST_B: mem[rw] <= (mem[rw] & ~(32'hFF << rsh))
                       | ((ram_wdata & 32'hFF) << rsh);
        ST_HW: mem[rw] <= (mem[rw] & ~(32'hFFFF << rsh))
                        | ((ram_wdata & 32'hFFFF) << rsh);
        default: mem[rw] <= ram_wdata;
      endcase
    end
    ram_rdata <= mem[rw];
  end

  task automatic do_req(
    input  logic        we,
    input  logic [2:0]  f3,
    input  logic [31:0] a,
    input  logic [31:0] d,
    output int          lat,
    output logic [31:0] rd,
    output logic        er,
    output logic        we1,
    output logic [1:0]  c1,
    output logic [31:0] a1,
    output logic [31:0] d1,
    output logic        rdy1,
    output int          wes
  );
    int g;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    g = 0;
    while (!bus.req_ready && g < 10) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 99; rd = 32'hX; er = 1'bx;
    we1 = 1'b0; c1 = 2'd0; a1 = 32'd0; d1 = 32'd0;
    rdy1 = 1'b1; wes = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) begin
        we1 = ram_we; c1 = ram_mem_ctrl;
        a1 = ram_address; d1 = ram_wdata;
        rdy1 = bus.req_ready;
      end
      if (ram_we) wes++;
      if (bus.resp_valid) begin
        lat = i;
        rd  = bus.resp_rdata;
        er  = bus.resp_err;
        break;
      end
    end
  endtask

  task automatic test_reset;
    total++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 ||
        bus.resp_err !== 1'b0 || bus.resp_rdata !== 32'd0) begin
      bad++;
      $display("FAIL reset_resp: rdy=%b v=%b e=%b d=%h want 1 0 0 0",
               bus.req_ready, bus.resp_valid,
               bus.resp_err, bus.resp_rdata);
    end
    total++;
    if (ram_we !== 1'b0 || ram_mem_ctrl !== 2'd0 ||
        ram_address !== 32'd0 || ram_wdata !== 32'd0) begin
      bad++;
      $display("FAIL reset_ram: we=%b c=%b a=%h d=%h want zeros",
               ram_we, ram_mem_ctrl, ram_address, ram_wdata);
    end
  endtask

  task automatic chk_load(
    input string nm, input logic [2:0] f3,
    input logic [31:0] a, input logic [31:0] exp
  );
    int lat, wes;
    logic [31:0] rd, a1, d1;
    logic er, we1, rdy1;
    logic [1:0] c1;
    do_req(1'b0, f3, a, 32'h0, lat, rd, er,
           we1, c1, a1, d1, rdy1, wes);
    total++;
    if (lat !== 3 || er !== 1'b0 || rd !== exp || wes !== 0) begin
      bad++;
      $display("FAIL %s: lat=%0d err=%b data=%h we=%0d want 3 0 %h 0",
               nm, lat, er, rd, wes, exp);
    end
  endtask

  task automatic chk_store(
    input string nm, input logic [2:0] f3,
    input logic [31:0] a, input logic [31:0] d,
    input logic [1:0] ctrl
  );
    int lat, wes;
    logic [31:0] rd, a1, d1;
    logic er, we1, rdy1;
    logic [1:0] c1;
    do_req(1'b1, f3, a, d, lat, rd, er,
           we1, c1, a1, d1, rdy1, wes);
    total++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'd0 || wes !== 1) begin
      bad++;
      $display("FAIL %s: lat=%0d err=%b data=%h we=%0d want 2 0 0 1",
               nm, lat, er, rd, wes);
    end
    total++;
    if (we1 !== 1'b1 || c1 !== ctrl || a1 !== a ||
        d1 !== d || rdy1 !== 1'b0) begin
      bad++;
      $display("FAIL %s_bus: we=%b c=%b a=%h d=%h rdy=%b want 1 %b %h %h 0",
               nm, we1, c1, a1, d1, rdy1, ctrl, a, d);
    end
  endtask

  task automatic chk_err(
    input string nm, input logic we, input logic [2:0] f3,
    input logic [31:0] a
  );
    int lat, wes;
    logic [31:0] rd, a1, d1;
    logic er, we1, rdy1;
    logic [1:0] c1;
    do_req(we, f3, a, 32'h5555AAAA, lat, rd, er,
           we1, c1, a1, d1, rdy1, wes);
    total++;
    if (lat !== 1 || er !== 1'b1 || rd !== 32'd0 || wes !== 0) begin
      bad++;
      $display("FAIL %s: lat=%0d err=%b data=%h we=%0d want 1 1 0 0",
               nm, lat, er, rd, wes);
    end
  endtask

  task automatic test_word;
    chk_store("sw_10", 3'b010, 32'h10, 32'hDEADBEEF, ST_W);
    chk_load("lw_10", 3'b010, 32'h10, 32'hDEADBEEF);
  endtask

  task automatic test_byte;
    chk_store("sb_13", 3'b000, 32'h13, 32'h000000AA, ST_B);
    chk_load("lb_13", 3'b000, 32'h13, 32'hFFFFFFAA);
    chk_load("lbu_13", 3'b100, 32'h13, 32'h000000AA);
    chk_load("lw_10b", 3'b010, 32'h10, 32'hAAADBEEF);
  endtask

  task automatic test_half;
    chk_load("lh_11", 3'b001, 32'h11, 32'hFFFFADBE);
    chk_load("lhu_11", 3'b101, 32'h11, 32'h0000ADBE);
    chk_store("sh_12", 3'b001, 32'h12, 32'h00001234, ST_HW);
    chk_load("lw_10h", 3'b010, 32'h10, 32'h1234BEEF);
    chk_load("lb_10", 3'b000, 32'h10, 32'hFFFFFFEF);
  endtask

  task automatic test_errors;
    chk_err("sh_13", 1'b1, 3'b001, 32'h13);
    chk_err("lw_12", 1'b0, 3'b010, 32'h12);
    chk_err("lbu_st", 1'b1, 3'b100, 32'h10);
    chk_err("f3_011", 1'b0, 3'b011, 32'h10);
    chk_err("lw_400", 1'b0, 3'b010, 32'h400);
    chk_load("lw_10e", 3'b010, 32'h10, 32'h1234BEEF);
  endtask

  task automatic test_range;
    chk_store("sw_3fc", 3'b010, 32'h3FC, 32'hCAFEF00D, ST_W);
    chk_load("lw_3fc", 3'b010, 32'h3FC, 32'hCAFEF00D);
  endtask

  task automatic test_reset_mid;
    int nv;
    // store interrupted in WRITE: ram_we must drop at once
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1;
    bus.req_funct3 = 3'b010; bus.req_addr = 32'h20;
    bus.req_wdata = 32'h11111111;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (ram_we !== 1'b0 || bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_write: we=%b rdy=%b want 0 1",
               ram_we, bus.req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // load interrupted in READ
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0;
    bus.req_funct3 = 3'b010; bus.req_addr = 32'h10;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.resp_valid) nv++;
    end
    total++;
    if (nv !== 0 || bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_read: resp=%0d rdy=%b want 0 1",
               nv, bus.req_ready);
    end
    chk_load("lw_after_rst", 3'b010, 32'h10, 32'h1234BEEF);
  endtask

  task automatic test_back_to_back;
    int nr;
    logic [31:0] rd;
    logic rdy1;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0;
    bus.req_funct3 = 3'b010; bus.req_addr = 32'h3FC;
    @(posedge clk);
    // fields change while busy and must be ignored
    #1 bus.req_addr = 32'h10;
    bus.req_funct3 = 3'b000;
    nr = 0; rd = 32'd0; rdy1 = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) rdy1 = bus.req_ready;
      if (bus.resp_valid) begin
        nr++;
        rd = bus.resp_rdata;
        bus.req_valid = 1'b0;
      end
    end
    bus.req_valid = 1'b0;
    total++;
    if (nr !== 1 || rd !== 32'hCAFEF00D || rdy1 !== 1'b0) begin
      bad++;
      $display("FAIL held_valid: resp=%0d data=%h rdy=%b want 1 cafef00d 0",
               nr, rd, rdy1);
    end
    total++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 ||
        bus.resp_rdata !== 32'd0) begin
      bad++;
      $display("FAIL idle_after: v=%b rdy=%b d=%h want 0 1 0",
               bus.resp_valid, bus.req_ready, bus.resp_rdata);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr = 32'd0;
    bus.req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_range();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
